// File: rtl/multicycle_controller_if.sv
// Memory handshake bundle between the multicycle controller (master) and the
// instruction/data memories (slave).
interface multicycle_controller_if;
    logic       im_req;
    logic       im_ready;
    logic       dm_req;
    logic       dm_ready;
    logic [3:0] dm_w_en;

    modport master (
        output im_req,
        output dm_req,
        output dm_w_en,
        input  im_ready,
        input  dm_ready
    );

    modport slave (
        input  im_req,
        input  dm_req,
        input  dm_w_en,
        output im_ready,
        output dm_ready
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) with Moore datapath selects.
// Define CTRL_TIMEOUT_EN to add a memory-wait watchdog that halts after TIMEOUT_CYCLES.
module multicycle_controller #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_controller_if.master bus,
    input  logic [4:0]              opcode,
    input  logic [2:0]              func3,
    input  logic                    func7,
    input  logic                    b,
    output logic                    ir_en,
    output logic                    pc_en,
    output logic                    next_pc_sel,
    output logic                    wb_en,
    output logic                    jb_op1_sel,
    output logic                    alu_op1_sel,
    output logic                    alu_op2_sel,
    output logic                    wb_sel,
    output logic                    illegal,
    output logic                    timeout,
    output logic [2:0]              state,
    output logic [CNT_W-1:0]        instret
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_I      = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    state_t cur_state;
    state_t next_state;

    logic is_i;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jal;
    logic is_jalr;
    logic is_lui;
    logic is_auipc;
    logic legal;
    logic wait_expired;
    logic in_instr;

    logic       im_req_c;
    logic       dm_req_c;
    logic [3:0] dm_w_en_c;

    // func7 is only meaningful to the ALU decoder, not to sequencing.
    logic unused_inputs;
    assign unused_inputs = func7 ^ (TIMEOUT_CYCLES < 1);

    function automatic logic is_legal(input logic [4:0] op, input logic [2:0] f3);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_JALR, OP_BRANCH,
            OP_LUI, OP_AUIPC, OP_JAL: return 1'b1;
            OP_STORE:                 return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
            default:                  return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] f3);
        case (f3)
            3'b000:  return 4'b0001;
            3'b001:  return 4'b0011;
            3'b010:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    assign is_i      = (opcode == OP_I);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_lui    = (opcode == OP_LUI);
    assign is_auipc  = (opcode == OP_AUIPC);
    assign legal     = is_legal(opcode, func3);

`ifdef CTRL_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] wait_cnt;
    logic            waiting;

    assign waiting = ((cur_state == FETCH) && !bus.im_ready) ||
                     ((cur_state == MEM)   && !bus.dm_ready);
    // Terminal count only fires on a cycle without ready, so a late ready always wins.
    assign wait_expired = waiting && (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Counter rests at 0 outside a wait, so every entry to FETCH or MEM starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (waiting && !wait_expired) begin
            wait_cnt <= wait_cnt + TO_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout <= 1'b0;
        end else if (wait_expired) begin
            timeout <= 1'b1;
        end
    end
`else
    assign wait_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= FETCH;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            FETCH: begin
                if (bus.im_ready) begin
                    next_state = DECODE;
                end else if (wait_expired) begin
                    next_state = HALT;
                end
            end
            DECODE: next_state = legal ? EXEC : HALT;
            EXEC: begin
                if (is_load || is_store) begin
                    next_state = MEM;
                end else if (is_branch) begin
                    next_state = FETCH;
                end else begin
                    next_state = WB;
                end
            end
            MEM: begin
                if (bus.dm_ready) begin
                    next_state = is_store ? FETCH : WB;
                end else if (wait_expired) begin
                    next_state = HALT;
                end
            end
            WB:      next_state = FETCH;
            HALT:    next_state = HALT;
            default: next_state = FETCH;
        endcase
    end

    assign in_instr = (cur_state == DECODE) || (cur_state == EXEC) ||
                      (cur_state == MEM)    || (cur_state == WB);

    // Everything is gated by rst_n so a reset mid-instruction kills writes immediately.
    always_comb begin
        im_req_c    = 1'b0;
        dm_req_c    = 1'b0;
        dm_w_en_c   = 4'b0000;
        ir_en       = 1'b0;
        pc_en       = 1'b0;
        wb_en       = 1'b0;
        jb_op1_sel  = 1'b0;
        alu_op1_sel = 1'b0;
        alu_op2_sel = 1'b0;
        wb_sel      = 1'b0;
        if (rst_n) begin
            if (in_instr) begin
                jb_op1_sel  = is_branch | is_jal;
                alu_op1_sel = is_jal | is_jalr | is_auipc;
                alu_op2_sel = is_i | is_load | is_store | is_lui | is_auipc;
                wb_sel      = is_load;
            end
            case (cur_state)
                FETCH: begin
                    im_req_c = 1'b1;
                    ir_en    = bus.im_ready;
                end
                EXEC: pc_en = is_branch;
                MEM: begin
                    dm_req_c  = 1'b1;
                    dm_w_en_c = is_store ? store_mask(func3) : 4'b0000;
                    pc_en     = is_store & bus.dm_ready;
                end
                WB: begin
                    wb_en = 1'b1;
                    pc_en = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign next_pc_sel = !(is_jal || is_jalr || (is_branch && b));
    assign bus.im_req  = im_req_c;
    assign bus.dm_req  = dm_req_c;
    assign bus.dm_w_en = dm_w_en_c;
    assign state       = cur_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal <= 1'b0;
        end else if ((cur_state == DECODE) && !legal) begin
            illegal <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= '0;
        end else if (pc_en) begin
            instret <= instret + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle scoreboard of expected FSM outputs
// built from the instruction stream, plus reset, halt and (optional) timeout scenarios.
module tb_multicycle_controller;

    localparam int CW = 3;

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_I      = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_BAD    = 5'b11111;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    typedef struct packed {
        logic [2:0] fsm;
        logic       ir;
        logic       pc;
        logic       wb;
        logic [3:0] we;
        logic [3:0] sel;
    } cyc_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          im_ready;
    logic          dm_ready;
    logic [4:0]    opcode;
    logic [2:0]    func3;
    logic          func7;
    logic          b;
    logic          ir_en;
    logic          pc_en;
    logic          next_pc_sel;
    logic          wb_en;
    logic          jb_op1_sel;
    logic          alu_op1_sel;
    logic          alu_op2_sel;
    logic          wb_sel;
    logic          illegal;
    logic          timeout;
    logic [2:0]    state;
    logic [CW-1:0] instret;

    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] model_cnt;
    cyc_t          exp_q[$];
    logic          nps_q[$];

    multicycle_controller_if bus_if();
    assign bus_if.im_ready = im_ready;
    assign bus_if.dm_ready = dm_ready;

    multicycle_controller #(.CNT_W(CW), .TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_if),
        .opcode      (opcode),
        .func3       (func3),
        .func7       (func7),
        .b           (b),
        .ir_en       (ir_en),
        .pc_en       (pc_en),
        .next_pc_sel (next_pc_sel),
        .wb_en       (wb_en),
        .jb_op1_sel  (jb_op1_sel),
        .alu_op1_sel (alu_op1_sel),
        .alu_op2_sel (alu_op2_sel),
        .wb_sel      (wb_sel),
        .illegal     (illegal),
        .timeout     (timeout),
        .state       (state),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected per-cycle behaviour of one instruction with zero fetch wait.
    task automatic push_expect(input logic [4:0] op, input logic [2:0] f3, input logic bv,
                               input int wait_n);
        logic       ld;
        logic       st;
        logic       br;
        logic [3:0] s;
        logic [3:0] mask;
        cyc_t       c;
        ld   = (op == OP_LOAD);
        st   = (op == OP_STORE);
        br   = (op == OP_BRANCH);
        s    = {br | (op == OP_JAL),
                (op == OP_JAL) | (op == OP_JALR) | (op == OP_AUIPC),
                (op == OP_I) | ld | st | (op == OP_LUI) | (op == OP_AUIPC),
                ld};
        mask = (f3 == 3'b000) ? 4'b0001 : (f3 == 3'b001) ? 4'b0011 : 4'b1111;
        c = '{fsm: S_FETCH, ir: 1'b1, pc: 1'b0, wb: 1'b0, we: 4'h0, sel: 4'h0};
        exp_q.push_back(c);
        c = '{fsm: S_DECODE, ir: 1'b0, pc: 1'b0, wb: 1'b0, we: 4'h0, sel: s};
        exp_q.push_back(c);
        c = '{fsm: S_EXEC, ir: 1'b0, pc: br, wb: 1'b0, we: 4'h0, sel: s};
        exp_q.push_back(c);
        if (ld || st) begin
            for (int k = 0; k <= wait_n; k++) begin
                c = '{fsm: S_MEM, ir: 1'b0, pc: st && (k == wait_n), wb: 1'b0,
                      we: st ? mask : 4'h0, sel: s};
                exp_q.push_back(c);
            end
        end
        if (!br && !st) begin
            c = '{fsm: S_WB, ir: 1'b0, pc: 1'b1, wb: 1'b1, we: 4'h0, sel: s};
            exp_q.push_back(c);
        end
        nps_q.push_back(!((op == OP_JAL) || (op == OP_JALR) || (br && bv)));
        model_cnt = model_cnt + CW'(1);
    endtask

    // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 back in FETCH.
    task automatic run_instr(input string tag, input logic [4:0] op, input logic [2:0] f3,
                             input logic bv, input int wait_n);
        int   mem_seen;
        int   budget;
        cyc_t c;
        logic nps;
        mem_seen = 0;
        budget   = 0;
        push_expect(op, f3, bv, wait_n);
        opcode   = op;
        func3    = f3;
        b        = bv;
        func7    = 1'($urandom_range(0, 1));
        im_ready = 1'b1;
        dm_ready = 1'b0;
        while (exp_q.size() > 0 && budget < 64) begin
            budget++;
            dm_ready = bus_if.dm_req && (mem_seen == wait_n);
            @(negedge clk);
            c = exp_q.pop_front();
            chk({tag, ".state"},   32'(state),   32'(c.fsm));
            chk({tag, ".ir_en"},   32'(ir_en),   32'(c.ir));
            chk({tag, ".pc_en"},   32'(pc_en),   32'(c.pc));
            chk({tag, ".wb_en"},   32'(wb_en),   32'(c.wb));
            chk({tag, ".dm_w_en"}, 32'(bus_if.dm_w_en), 32'(c.we));
            chk({tag, ".sel"},     32'({jb_op1_sel, alu_op1_sel, alu_op2_sel, wb_sel}), 32'(c.sel));
            chk({tag, ".im_req"},  32'(bus_if.im_req), 32'(c.fsm == S_FETCH));
            chk({tag, ".dm_req"},  32'(bus_if.dm_req), 32'(c.fsm == S_MEM));
            if (c.pc && nps_q.size() > 0) begin
                nps = nps_q.pop_front();
                chk({tag, ".next_pc_sel"}, 32'(next_pc_sel), 32'(nps));
            end
            if (bus_if.dm_req) mem_seen++;
            @(posedge clk);
            #1;
        end
        dm_ready = 1'b0;
        chk({tag, ".drain"},   32'(exp_q.size()), 32'd0);
        chk({tag, ".instret"}, 32'(instret), 32'(model_cnt));
        chk({tag, ".illegal"}, 32'(illegal), 32'd0);
    endtask

    // Asserts reset, checks forced values, releases and checks the first post-reset cycle.
    task automatic do_reset(input string tag);
        im_ready = 1'b0;
        dm_ready = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk({tag, ".rst_state"},  32'(state), 32'(S_FETCH));
        chk({tag, ".rst_req"},    32'({bus_if.im_req, bus_if.dm_req}), 32'd0);
        chk({tag, ".rst_strobe"}, 32'({ir_en, pc_en, wb_en}), 32'd0);
        chk({tag, ".rst_we"},     32'(bus_if.dm_w_en), 32'd0);
        chk({tag, ".rst_flags"},  32'({illegal, timeout}), 32'd0);
        chk({tag, ".rst_instret"}, 32'(instret), 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        model_cnt = '0;
        exp_q.delete();
        nps_q.delete();
        @(posedge clk);
        #1;
        chk({tag, ".rel_im_req"}, 32'(bus_if.im_req), 32'd1);
        chk({tag, ".rel_state"},  32'(state), 32'(S_FETCH));
    endtask

    initial begin
        rst_n     = 1'b1;
        im_ready  = 1'b0;
        dm_ready  = 1'b0;
        opcode    = OP_R;
        func3     = 3'b000;
        func7     = 1'b0;
        b         = 1'b0;
        model_cnt = '0;
        #3;
        do_reset("por");

        run_instr("r_type",  OP_R,      3'b000, 1'b0, 0);
        run_instr("i_type",  OP_I,      3'b000, 1'b0, 0);
        run_instr("lw_w0",   OP_LOAD,   3'b010, 1'b0, 0);
        run_instr("lb_w2",   OP_LOAD,   3'b000, 1'b0, 2);
        run_instr("sw_w3",   OP_STORE,  3'b010, 1'b0, 3);
        run_instr("sb_w0",   OP_STORE,  3'b000, 1'b0, 0);
        run_instr("sh_w1",   OP_STORE,  3'b001, 1'b0, 1);
        run_instr("beq_t",   OP_BRANCH, 3'b000, 1'b1, 0);
        run_instr("beq_nt",  OP_BRANCH, 3'b000, 1'b0, 0);
        run_instr("jal",     OP_JAL,    3'b000, 1'b1, 0);
        run_instr("jalr",    OP_JALR,   3'b000, 1'b0, 0);
        run_instr("lui",     OP_LUI,    3'b000, 1'b0, 0);
        run_instr("auipc",   OP_AUIPC,  3'b000, 1'b0, 0);

        // Reset in the middle of a store's MEM phase.
        opcode   = OP_STORE;
        func3    = 3'b010;
        im_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("abort.pre_state",   32'(state), 32'(S_MEM));
        chk("abort.pre_we",      32'(bus_if.dm_w_en), 32'hf);
        chk("abort.pre_instret", 32'(instret), 32'(model_cnt));
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort.dm_req",  32'(bus_if.dm_req), 32'd0);
        chk("abort.dm_w_en", 32'(bus_if.dm_w_en), 32'd0);
        chk("abort.strobes", 32'({pc_en, wb_en}), 32'd0);
        chk("abort.state",   32'(state), 32'(S_FETCH));
        chk("abort.instret", 32'(instret), 32'd0);
        @(posedge clk);
        #1;
        im_ready  = 1'b0;
        rst_n     = 1'b1;
        model_cnt = '0;
        @(posedge clk);
        #1;
        chk("abort.rel_state",  32'(state), 32'(S_FETCH));
        chk("abort.rel_im_req", 32'(bus_if.im_req), 32'd1);

        // Undefined opcode halts and stays halted until reset.
        opcode   = OP_BAD;
        im_ready = 1'b1;
        @(negedge clk);
        chk("bad.fetch", 32'(state), 32'(S_FETCH));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bad.decode",  32'(state), 32'(S_DECODE));
        chk("bad.flag_lo", 32'(illegal), 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("halt.state",   32'(state), 32'(S_HALT));
            chk("halt.im_req",  32'(bus_if.im_req), 32'd0);
            chk("halt.outputs", 32'({ir_en, pc_en, wb_en, bus_if.dm_req, bus_if.dm_w_en}), 32'd0);
            chk("halt.illegal", 32'(illegal), 32'd1);
            @(posedge clk);
            #1;
        end
        do_reset("halt_clr");

        // Store with a width outside byte/half/word is illegal.
        opcode   = OP_STORE;
        func3    = 3'b011;
        im_ready = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("st011.state",   32'(state), 32'(S_HALT));
        chk("st011.illegal", 32'(illegal), 32'd1);
        do_reset("st011_clr");
        run_instr("post_rst", OP_I, 3'b000, 1'b0, 0);

`ifdef CTRL_TIMEOUT_EN
        // Fetch never answered: halts on the 16th waiting edge.
        do_reset("to_fetch");
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        chk("to_fetch.wait_state", 32'(state), 32'(S_FETCH));
        chk("to_fetch.wait_flag",  32'(timeout), 32'd0);
        @(posedge clk);
        #1;
        chk("to_fetch.state", 32'(state), 32'(S_HALT));
        chk("to_fetch.flag",  32'(timeout), 32'd1);
        @(posedge clk);
        #1;
        chk("to_fetch.hold", 32'({timeout, state}), 32'({1'b1, S_HALT}));

        // Ready on the terminal cycle wins over the timeout.
        do_reset("to_race");
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        opcode   = OP_R;
        im_ready = 1'b1;
        @(negedge clk);
        chk("to_race.ir_en", 32'(ir_en), 32'd1);
        @(posedge clk);
        #1;
        chk("to_race.state", 32'(state), 32'(S_DECODE));
        chk("to_race.flag",  32'(timeout), 32'd0);

        // Data memory never answers a store.
        do_reset("to_mem");
        opcode   = OP_STORE;
        func3    = 3'b000;
        im_ready = 1'b1;
        @(posedge clk);
        #1;
        im_ready = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        chk("to_mem.wait_state", 32'(state), 32'(S_MEM));
        @(posedge clk);
        #1;
        chk("to_mem.state", 32'(state), 32'(S_HALT));
        chk("to_mem.flag",  32'(timeout), 32'd1);
        do_reset("to_clr");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum memory wait cycles; only used when CTRL_TIMEOUT_EN is defined.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- opcode  in  5  instr[6:2], taken from the instruction register
- func3  in  3  instr[14:12]
- func7  in  1  instr[30]
- b  in  1  branch-taken flag from the comparator
- im_req, im_ready  out/in  1  instruction-fetch handshake
- dm_req, dm_ready  out/in  1  data-memory handshake
- ir_en  out  1  instruction-register load strobe
- pc_en  out  1  PC update strobe
- next_pc_sel  out  1  0 = jump/branch target, 1 = PC+4
- wb_en  out  1  register-file write enable
- jb_op1_sel, alu_op1_sel, alu_op2_sel, wb_sel  out  1 each  datapath selects
- dm_w_en  out  4  byte write enables
- illegal  out  1  sticky illegal-instruction flag
- timeout  out  1  sticky memory-timeout flag
- state  out  3  current state, for debug
- instret  out  CNT_W  retired-instruction count

Function
REQ-004 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; all other outputs SHALL be Moore outputs of the state register plus the opcode/func3/b inputs.
REQ-005 FETCH SHALL behave as follows:
- im_req=1.
- On im_ready=1: ir_en=1 for that cycle only, next state DECODE.
- Otherwise remain in FETCH.
REQ-006 DECODE SHALL behave as follows:
- Legal opcodes: 01100, 00100, 00000, 11001, 01000, 11000, 01101, 00101, 11011.
- Opcode 01000 is legal only with func3 in {000, 001, 010}.
- Legal instruction: next state EXEC.
- Illegal instruction: set illegal and go to HALT.
REQ-007 EXEC SHALL select the next state by opcode:
- Load or store: MEM.
- Branch: pc_en=1 that cycle, then FETCH.
- All others: WB.
REQ-008 MEM SHALL behave as follows:
- dm_req=1.
- Store: dm_w_en = 0001/0011/1111 for func3 000/001/010, held until dm_ready.
- On dm_ready, load: next state WB.
- On dm_ready, store: pc_en=1 that cycle, then FETCH.
REQ-009 WB SHALL assert wb_en=1 and pc_en=1 for one cycle, then go to FETCH.
REQ-010 next_pc_sel SHALL be:
- 0 for jal and jalr.
- 0 for a branch when b=1.
- 1 otherwise.
- Guaranteed valid only in cycles where pc_en=1.
REQ-011 Datapath selects SHALL be driven from DECODE through the last state of the instruction, using the single-cycle encoding:
- alu_op1_sel=1 for jal, jalr, auipc.
- alu_op2_sel=1 for I-type, load, store, lui, auipc.
- wb_sel=1 for load.
- jb_op1_sel=1 for branch and jal.
- Every don't-care SHALL be driven 0.
REQ-012 wb_en and dm_w_en SHALL be 0 outside WB and MEM respectively; dm_w_en SHALL be 0 for loads.
REQ-013 instret SHALL increment by 1 on every cycle where pc_en=1 and SHALL wrap from all-ones to 0.
REQ-014 Latency with zero memory wait SHALL be: branch 3 cycles; R-type, I-type, U-type, jal, jalr and store 4 cycles; load 5 cycles.
REQ-015 HALT SHALL behave as follows:
- All request, strobe and enable outputs are 0.
- illegal and timeout hold their values.
- HALT is left only by reset.

Reset
REQ-016 While rst_n=0, the block SHALL force the following, asynchronously:
- State = FETCH.
- im_req, dm_req, ir_en, pc_en, wb_en = 0.
- dm_w_en = 0.
- illegal, timeout = 0.
- instret = 0.
- Timeout counter = 0.
REQ-017 On rst_n release, im_req SHALL be 1 from the first clk edge onward.
REQ-018 Reset asserted mid-instruction SHALL abort it with no register or memory write and no instret increment.

Configuration
REQ-019 With macro CTRL_TIMEOUT_EN defined, the block SHALL apply a memory timeout:
- Wait counter is cleared on entry to FETCH or MEM.
- Counter increments on each cycle in that state without ready.
- When it reaches TIMEOUT_CYCLES, timeout is set and the next state is HALT.
- If ready arrives in the same cycle as terminal count, ready SHALL win.
REQ-020 Without CTRL_TIMEOUT_EN, the timeout counter SHALL be absent, timeout SHALL be tied to 0, and FETCH/MEM SHALL wait indefinitely.

Verification
REQ-021 im_ready=1 constantly, opcode 01100 -> state sequence 0,1,2,4; wb_en=1 only in cycle 4; instret goes 0 to 1.
REQ-022 Store opcode 01000 func3 010, dm_ready asserted on the 4th MEM cycle:
- dm_w_en=1111 for exactly 4 cycles.
- wb_en never asserted.
- pc_en asserted exactly once.
REQ-023 Branch opcode 11000 with b=1 -> pc_en=1 and next_pc_sel=0 in cycle 3; with b=0 -> next_pc_sel=1.
REQ-024 Opcode 11111 -> HALT (state=5); illegal=1; im_req=0 held for 20 cycles until rst_n pulse.
REQ-025 CTRL_TIMEOUT_EN defined, im_ready=0 -> timeout=1 and state=5 after 16 FETCH cycles; repeat with im_ready=1 on the 16th cycle -> DECODE, timeout=0.
REQ-026 rst_n driven low in MEM of a store -> dm_req and dm_w_en drop within the same cycle; instret=0; FETCH on release.
